// File: rtl/proc_pkg.sv
// Shared fetch-stage definitions.
//   ADDR_W / WORD_W / BOFS_W : default address, instruction and branch-offset widths
//   HALT_OP                  : instruction encoding that ends the program
//   fetch_state_t            : fetch FSM states
//   addr_t / word_t          : address and instruction word types
package proc_pkg;
  localparam int ADDR_W = 16;
  localparam int WORD_W = 9;
  localparam int BOFS_W = 8;

  localparam logic [WORD_W-1:0] HALT_OP = 9'h1FF;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_t;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: control from downstream, ROM data in, fetch results out.
//   master : downstream/ROM side (drives Start, Stall, branch inputs, InstIn)
//   slave  : fetch stage (drives InstAddress, InstOut, InstPC, InstValid, Done, CycleCount)
interface inst_fetch_if #(
  parameter int A     = 16,
  parameter int W     = 9,
  parameter int OFS_W = 8
);
  logic             Start;
  logic             Stall;
  logic             BranchTaken;
  logic             BranchAbs;
  logic [A-1:0]     BranchTarget;
  logic [OFS_W-1:0] BranchOffset;
  logic [W-1:0]     InstIn;
  logic [A-1:0]     InstAddress;
  logic [W-1:0]     InstOut;
  logic [A-1:0]     InstPC;
  logic             InstValid;
  logic             Done;
  logic [31:0]      CycleCount;

  modport master (
    output Start, Stall, BranchTaken, BranchAbs, BranchTarget, BranchOffset, InstIn,
    input  InstAddress, InstOut, InstPC, InstValid, Done, CycleCount
  );

  modport slave (
    input  Start, Stall, BranchTaken, BranchAbs, BranchTarget, BranchOffset, InstIn,
    output InstAddress, InstOut, InstPC, InstValid, Done, CycleCount
  );
endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection.
//   pc, inst_pc          : current PC and address of the instruction in decode
//   stall                : hold PC
//   branch_taken/abs     : redirect; absolute target or inst_pc-relative offset
//   branch_target/offset : branch operands (offset is two's complement)
//   pc_next              : selected next PC, all arithmetic modulo 2**A
module pc_next_calc #(
  parameter int A     = 16,
  parameter int OFS_W = 8
) (
  input  logic [A-1:0]     pc,
  input  logic [A-1:0]     inst_pc,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic             branch_abs,
  input  logic [A-1:0]     branch_target,
  input  logic [OFS_W-1:0] branch_offset,
  output logic [A-1:0]     pc_next
);
  logic [A-1:0] ofs_sext;

  assign ofs_sext = {{(A-OFS_W){branch_offset[OFS_W-1]}}, branch_offset};

  always_comb begin
    pc_next = pc + A'(1);
    if (stall)
      pc_next = pc;
    else if (branch_taken)
      pc_next = branch_abs ? branch_target : inst_pc + ofs_sext;
  end
endmodule

// File: rtl/inst_fetch.sv
// PC / fetch stage in front of the instruction ROM.
//   CLK, Reset : clock and synchronous active-high reset
//   bus        : inst_fetch_if slave (control in, ROM data in, fetch results out)
// Optional build macro FETCH_CYCLE_COUNT_EN: saturating count of RUN cycles on
// CycleCount; without it CycleCount is tied to 0.
module inst_fetch import proc_pkg::*; #(
  parameter int           A          = ADDR_W,
  parameter int           W          = WORD_W,
  parameter int           OFS_W      = BOFS_W,
  parameter logic [A-1:0] START_ADDR = '0,
  parameter logic [W-1:0] HALT_OP    = proc_pkg::HALT_OP
) (
  input  logic        CLK,
  input  logic        Reset,
  inst_fetch_if.slave bus
);
  fetch_state_t state;
  logic [A-1:0] pc;
  logic [A-1:0] pc_next;
  logic [W-1:0] inst_out;
  logic [A-1:0] inst_pc;
  logic         inst_valid;
  logic         done;
  // Halt word is on InstOut (valid) for one cycle before HALTED/Done.
  logic         halt_pend;

  pc_next_calc #(.A(A), .OFS_W(OFS_W)) u_pc_next (
    .pc            (pc),
    .inst_pc       (inst_pc),
    .stall         (bus.Stall),
    .branch_taken  (bus.BranchTaken),
    .branch_abs    (bus.BranchAbs),
    .branch_target (bus.BranchTarget),
    .branch_offset (bus.BranchOffset),
    .pc_next       (pc_next)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= IDLE;
      pc         <= START_ADDR;
      inst_out   <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      done       <= 1'b0;
      halt_pend  <= 1'b0;
    end else if (bus.Start) begin
      state      <= RUN;
      pc         <= START_ADDR;
      inst_valid <= 1'b0;
      done       <= 1'b0;
      halt_pend  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (halt_pend) begin
            state      <= HALTED;
            done       <= 1'b1;
            inst_valid <= 1'b0;
            halt_pend  <= 1'b0;
          end else if (!bus.Stall) begin
            if (bus.BranchTaken) begin
              // Word fetched this cycle is wrong-path: drop it.
              pc         <= pc_next;
              inst_valid <= 1'b0;
            end else begin
              inst_out   <= bus.InstIn;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              if (bus.InstIn == HALT_OP) halt_pend <= 1'b1;
              else                       pc        <= pc_next;
            end
          end
        end
        default: inst_valid <= 1'b0;
      endcase
    end
  end

`ifdef FETCH_CYCLE_COUNT_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge CLK) begin
    if (Reset || bus.Start)
      cycle_cnt <= '0;
    else if (state == RUN && cycle_cnt != 32'hFFFF_FFFF)
      cycle_cnt <= cycle_cnt + 32'd1;
  end

  assign bus.CycleCount = cycle_cnt;
`else
  assign bus.CycleCount = '0;
`endif

  assign bus.InstAddress = pc;
  assign bus.InstOut     = inst_out;
  assign bus.InstPC      = inst_pc;
  assign bus.InstValid   = inst_valid;
  assign bus.Done        = done;
endmodule
